controller_reader: RTL and testbench

Serial gamepad front end that produces the 10-bit `input_data` word and the `trigger` strobe consumed by the player logic. On each frame tick it latches an SNES-style 12-button shift-register controller, shifts out all buttons, remaps them to the game's button word and publishes the word with a one-cycle trigger. It sits between the controller pins and the player/game-state logic.

---
 rtl/controller_pkg.sv | 51 +++++
 rtl/input_sync.sv | 15 +
 rtl/controller_reader.sv | 88 ++++++++
 tb/tb_controller_reader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// controller_pkg: shared state encoding, serial button indices and input_data bit positions
package controller_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LATCH   = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;
    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        LATCH   = ST_LATCH,
        SHIFT   = ST_SHIFT,
        PUBLISH = ST_PUBLISH
    } state_t;
    localparam int NUM_BUTTONS = 12;
    localparam int SER_B      = 0;
    localparam int SER_Y      = 1;
    localparam int SER_SELECT = 2;
    localparam int SER_START  = 3;
    localparam int SER_UP     = 4;
    localparam int SER_DOWN   = 5;
    localparam int SER_LEFT   = 6;
    localparam int SER_RIGHT  = 7;
    localparam int SER_A      = 8;
    localparam int SER_X      = 9;
    localparam int SER_L      = 10;
    localparam int SER_R      = 11;
    localparam int BIT_ATTACK = 9;
    localparam int BIT_RIGHT  = 8;
    localparam int BIT_LEFT   = 7;
    localparam int BIT_DOWN   = 6;
    localparam int BIT_UP     = 5;
    localparam int BIT_SWORD  = 4;
    localparam int BIT_START  = 3;
    localparam int BIT_SELECT = 2;
    localparam int BIT_L      = 1;
    localparam int BIT_R      = 0;
    function automatic logic [9:0] remap(input logic [NUM_BUTTONS-1:0] sr);
        logic [9:0] w;
        w = '0;
        w[BIT_ATTACK] = sr[SER_A];
        w[BIT_RIGHT]  = sr[SER_RIGHT];
        w[BIT_LEFT]   = sr[SER_LEFT];
        w[BIT_DOWN]   = sr[SER_DOWN];
        w[BIT_UP]     = sr[SER_UP];
        w[BIT_SWORD]  = sr[SER_B];
        w[BIT_START]  = sr[SER_START];
        w[BIT_SELECT] = sr[SER_SELECT];
        w[BIT_L]      = sr[SER_L];
        w[BIT_R]      = sr[SER_R];
        return w;
    endfunction
endpackage

// File: rtl/input_sync.sv
// input_sync: 2-flop synchronizer with parameterised reset value (clk, reset, d in; q out)
module input_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (reset) {q, meta} <= {RESET_VAL, RESET_VAL};
        else       {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/controller_reader.sv
// controller_reader: scans a 12-button serial pad per frame tick, publishes a 10-bit word with a trigger strobe
module controller_reader
    import controller_pkg::*;
#(
    parameter int CLK_DIV = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [9:0] input_data,
    output logic       trigger,
    output logic       busy,
    output logic       overrun
);
    localparam logic [9:0] LAST_PH = 10'(CLK_DIV - 1);
    state_t state;
    logic [9:0] phase;
    logic half;
    logic [3:0] bit_idx;
    logic [NUM_BUTTONS-1:0] sr;
    logic pad_sync;
    logic end_half;
    input_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_data),
        .q     (pad_sync)
    );
    assign end_half = phase == LAST_PH;
    always_ff @(posedge clk) begin
        trigger <= 1'b0;
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            half       <= 1'b0;
            bit_idx    <= '0;
            sr         <= '0;
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b1;
            input_data <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (frame_tick && state != IDLE) overrun <= 1'b1;
            if (state == LATCH || state == SHIFT) begin
                phase <= end_half ? '0 : phase + 10'd1;
                if (end_half) half <= ~half;
            end
            case (state)
                IDLE: if (frame_tick) begin
                    state     <= LATCH;
                    phase     <= '0;
                    half      <= 1'b0;
                    bit_idx   <= '0;
                    pad_latch <= 1'b1;
                    busy      <= 1'b1;
                end
                LATCH: if (end_half && half) begin
                    state     <= SHIFT;
                    pad_latch <= 1'b0;
                end
                SHIFT: begin
                    if (end_half && !half) begin
                        sr[bit_idx] <= ~pad_sync;
                        pad_clk     <= 1'b0;
                    end
                    if (end_half && half) begin
                        pad_clk <= 1'b1;
                        if (bit_idx == 4'd11) state <= PUBLISH;
                        else bit_idx <= bit_idx + 4'd1;
                    end
                end
                PUBLISH: if (!half) begin
                    input_data <= remap(sr);
                    half       <= 1'b1;
                end else begin
                    trigger <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_controller_reader.sv
// tb_controller_reader: randomized scoreboard bench with a behavioural pad model and timing reference
module tb_controller_reader;
    localparam int C = 4;
    localparam int SCAN = 26 * C + 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic pad_data;
    logic pad_latch, pad_clk, trigger, busy, overrun;
    logic [9:0] input_data;
    always #5 clk = ~clk;
    controller_reader #(.CLK_DIV(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .input_data (input_data),
        .trigger    (trigger),
        .busy       (busy),
        .overrun    (overrun)
    );
    logic [11:0] btn = '0;
    logic [11:0] held = '0;
    logic [3:0] idx = 4'd12;
    always @(posedge pad_latch) begin
        held = btn;
        idx = 4'd0;
    end
    always @(posedge pad_clk) begin
        if (!pad_latch && idx < 4'd12) idx = idx + 4'd1;
    end
    assign pad_data = (idx < 4'd12) ? ~held[idx] : 1'b1;
    function automatic logic [9:0] expect_word(input logic [11:0] b);
        return {b[8], b[7], b[6], b[5], b[4], b[0], b[3], b[2], b[10], b[11]};
    endfunction
    typedef struct {
        int         t;
        logic [9:0] word;
    } scan_t;
    scan_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic rst_q = 1'b0;
    logic armed = 1'b0;
    logic ovr_pend = 1'b0;
    logic exp_ovr = 1'b0;
    logic [9:0] exp_data = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_q <= reset;
    end
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask
    always @(negedge clk) begin
        int e, r;
        logic eb, el, ec, et;
        eb = 1'b0; el = 1'b0; ec = 1'b1; et = 1'b0; e = 0; r = 0;
        if (rst_q) begin
            q.delete();
            exp_data = '0;
            exp_ovr = 1'b0;
            ovr_pend = 1'b0;
            armed = 1'b1;
        end else begin
            exp_ovr = exp_ovr | ovr_pend;
            ovr_pend = 1'b0;
        end
        if (armed) begin
            if (q.size() > 0) begin
                e = q[0].t + SCAN;
                r = cyc - q[0].t;
                eb = cyc >= q[0].t && cyc < e;
                el = r >= 0 && r < 2 * C;
                ec = !(r >= 2 * C && r < 26 * C && (r % (2 * C)) >= C);
                et = cyc == e;
                if (cyc == e - 1) exp_data = q[0].word;
            end
            chk("busy", 32'(busy), 32'(eb));
            chk("pad_latch", 32'(pad_latch), 32'(el));
            chk("pad_clk", 32'(pad_clk), 32'(ec));
            chk("trigger", 32'(trigger), 32'(et));
            chk("input_data", 32'(input_data), 32'(exp_data));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            if (q.size() > 0 && cyc >= e) void'(q.pop_front());
            if (frame_tick && !reset) begin
                if (q.size() == 0) q.push_back('{t: cyc + 1, word: expect_word(btn)});
                else ovr_pend = 1'b1;
            end
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask
    task automatic scan(input logic [11:0] b);
        btn = b;
        tick();
        step(SCAN + 2);
    endtask
    initial begin
        int gap;
        step(3);
        reset = 1'b0;
        step(100);
        scan(12'h100);
        scan(12'h051);
        scan(12'hFFF);
        scan(12'h202);
        btn = 12'($urandom_range(0, 4095));
        tick();
        step(20);
        tick();
        step(SCAN + 2);
        btn = 12'($urandom_range(0, 4095));
        tick();
        step(2 * C * 6 + 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(5);
        scan(12'($urandom_range(0, 4095)));
        for (int i = 0; i < 6; i++) begin
            btn = 12'($urandom_range(0, 4095));
            tick();
            gap = (i == 2) ? 0 : int'($urandom_range(1, 3));
            step(SCAN - 1 + gap);
        end
        step(SCAN + 2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
